// File: rtl/bcd_disp_pkg.sv
// Shared constants and helpers for the 3-digit BCD display scanner:
// segment patterns, slot encoding, prescaler derivation and parameter checks.
package bcd_disp_pkg;

    // Segment patterns are {g,f,e,d,c,b,a}, active-low.
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;

    typedef enum logic [1:0] {
        SLOT_UNITS    = 2'd0,
        SLOT_TENS     = 2'd1,
        SLOT_HUNDREDS = 2'd2,
        SLOT_UNUSED   = 2'd3
    } slot_t;

    function automatic logic [6:0] seg_of_digit(input logic [3:0] digit);
        logic [6:0] pattern;
        case (digit)
            4'd0:    pattern = 7'b1000000;
            4'd1:    pattern = 7'b1111001;
            4'd2:    pattern = 7'b0100100;
            4'd3:    pattern = 7'b0110000;
            4'd4:    pattern = 7'b0011001;
            4'd5:    pattern = 7'b0010010;
            4'd6:    pattern = 7'b0000010;
            4'd7:    pattern = 7'b1111000;
            4'd8:    pattern = 7'b0000000;
            4'd9:    pattern = 7'b0010000;
            default: pattern = SEG_DASH;
        endcase
        return pattern;
    endfunction

    function automatic logic nibble_invalid(input logic [3:0] nibble);
        return (nibble > 4'd9);
    endfunction

    function automatic logic word_invalid(input logic [11:0] word);
        return nibble_invalid(word[3:0]) | nibble_invalid(word[7:4]) |
               nibble_invalid(word[11:8]);
    endfunction

    function automatic int calc_div(input int clk_hz, input int slot_hz);
        return clk_hz / slot_hz;
    endfunction

    function automatic bit params_legal(input int div, input int dead_cycles);
        return (div >= 4) && (dead_cycles >= 0) && (dead_cycles < div);
    endfunction

endpackage

// File: rtl/bcd_to_seg7.sv
// Combinational BCD nibble to active-low 7-segment decoder with blanking.
// Out-of-range nibbles show a dash and override the blank request.
module bcd_to_seg7
    import bcd_disp_pkg::*;
(
    input  logic [3:0] nibble,
    input  logic       blank,
    output logic [6:0] seg
);

    // Dash has priority so an invalid digit is never hidden.
    always_comb begin
        seg = SEG_BLANK;
        if (nibble_invalid(nibble)) begin
            seg = SEG_DASH;
        end else if (blank) begin
            seg = SEG_BLANK;
        end else begin
            seg = seg_of_digit(nibble);
        end
    end

endmodule

// File: rtl/bcd12_display_scan.sv
// Latches a 12-bit BCD word and time-multiplexes it onto a 4-digit
// common-anode display with leading-zero blanking and a dead interval.
module bcd12_display_scan
    import bcd_disp_pkg::*;
#(
    parameter int CLK_HZ      = 100000000,
    parameter int SLOT_HZ     = 1000,
    parameter int DEAD_CYCLES = 16,
    parameter int LZ_BLANK    = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [11:0] data12,
    input  logic        data_valid,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp,
    output logic        err
);

    localparam int DIV = calc_div(CLK_HZ, SLOT_HZ);
    localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] DIV_LAST = PW'(DIV - 1);
    localparam logic [PW-1:0] DEAD_END = PW'(DEAD_CYCLES);
    localparam logic          LZ_ON    = (LZ_BLANK != 0);

    generate
        if (!params_legal(DIV, DEAD_CYCLES)) begin : g_bad_params
            $error("bcd12_display_scan: need DIV >= 4 and DEAD_CYCLES < DIV");
        end
    endgenerate

    logic [11:0]   shadow_r;
    logic          err_r;
    logic [PW-1:0] presc_r;
    slot_t         idx_r;
    logic [3:0]    an_r;
    logic [6:0]    seg_r;
    logic          dp_r;

    logic [3:0]    nib_s;
    logic          blank_s;
    logic [6:0]    dec_seg_s;
    logic [3:0]    an_next_s;
    logic [6:0]    seg_next_s;
    logic          hund_zero_s;
    logic          tens_zero_s;

    // Capture the BCD word and its validity on every strobe; last strobe wins.
    always_ff @(posedge clk) begin
        if (reset) begin
            shadow_r <= 12'h000;
            err_r    <= 1'b0;
        end else if (data_valid) begin
            shadow_r <= data12;
            err_r    <= word_invalid(data12);
        end else begin
            shadow_r <= shadow_r;
            err_r    <= err_r;
        end
    end

    // Slot prescaler and digit index; the index advances on prescaler wrap.
    always_ff @(posedge clk) begin
        if (reset) begin
            presc_r <= '0;
            idx_r   <= SLOT_UNITS;
        end else if (presc_r == DIV_LAST) begin
            presc_r <= '0;
            idx_r   <= slot_t'(idx_r + 2'd1);
        end else begin
            presc_r <= presc_r + PW'(1);
            idx_r   <= idx_r;
        end
    end

    // Invalid (non-zero) upper nibbles naturally defeat blanking here.
    always_comb begin
        hund_zero_s = (shadow_r[11:8] == 4'd0);
        tens_zero_s = (shadow_r[7:4] == 4'd0);
    end

    // Select the digit for the current slot and whether it is a leading zero.
    always_comb begin
        nib_s   = 4'd0;
        blank_s = 1'b1;
        case (idx_r)
            SLOT_UNITS: begin
                nib_s   = shadow_r[3:0];
                blank_s = 1'b0;
            end
            SLOT_TENS: begin
                nib_s   = shadow_r[7:4];
                blank_s = LZ_ON & tens_zero_s & hund_zero_s;
            end
            SLOT_HUNDREDS: begin
                nib_s   = shadow_r[11:8];
                blank_s = LZ_ON & hund_zero_s;
            end
            default: begin
                nib_s   = 4'd0;
                blank_s = 1'b1;
            end
        endcase
    end

    bcd_to_seg7 u_dec (
        .nibble (nib_s),
        .blank  (blank_s),
        .seg    (dec_seg_s)
    );

    // Next anode/segment pattern: dark during the dead interval and slot 3.
    always_comb begin
        an_next_s  = 4'b1111;
        seg_next_s = SEG_BLANK;
        if (presc_r < DEAD_END) begin
            an_next_s  = 4'b1111;
            seg_next_s = SEG_BLANK;
        end else if (idx_r == SLOT_UNUSED) begin
            an_next_s  = 4'b1111;
            seg_next_s = SEG_BLANK;
        end else begin
            an_next_s  = ~(4'b0001 << idx_r);
            seg_next_s = dec_seg_s;
        end
    end

    // Registered display outputs, one cycle behind the scan state.
    always_ff @(posedge clk) begin
        if (reset) begin
            an_r  <= 4'b1111;
            seg_r <= SEG_BLANK;
            dp_r  <= 1'b1;
        end else begin
            an_r  <= an_next_s;
            seg_r <= seg_next_s;
            dp_r  <= 1'b1;
        end
    end

    assign an  = an_r;
    assign seg = seg_r;
    assign dp  = dp_r;
    assign err = err_r;

endmodule

// File: doc/bcd12_display_scan.md
Name: bcd12_display_scan

Overview:
- Downstream consumer of the 12-bit BCD word from the UART byte-assembly stage.
- Latches three BCD digits on a one-cycle valid strobe and drives a 4-digit common-anode 7-segment display by time-multiplexing.
- Provides leading-zero blanking, invalid-digit flagging and an anti-ghosting dead interval.
- Sits between the BCD assembler and the board display pins.

Parameters:
- CLK_HZ, 100000000, system clock frequency in Hz.
- SLOT_HZ, 1000, per-digit refresh rate; slot length DIV = CLK_HZ/SLOT_HZ cycles, DIV >= 4 required.
- DEAD_CYCLES, 16, cycles at the start of each slot with all anodes off; must be < DIV.
- LZ_BLANK, 1, 1 enables leading-zero blanking on digits 2 and 1.

Ports:
- clk  in  1  system clock, all logic on posedge.
- reset  in  1  synchronous, active-high.
- data12  in  12  BCD word: [3:0] units, [7:4] tens, [11:8] hundreds.
- data_valid  in  1  one-cycle strobe, data12 valid this cycle.
- an  out  4  anodes, active-low; an[0] is the rightmost digit.
- seg  out  7  {g,f,e,d,c,b,a}, active-low.
- dp  out  1  decimal point, active-low, constant 1.
- err  out  1  high while any latched nibble > 9.

Behaviour:
- Reset values:
  - shadow register 12'h000, err 0.
  - prescaler 0, slot index 0.
  - an 4'b1111, seg 7'b1111111, dp 1.
- Load:
  - data_valid=1 at posedge N: shadow <= data12 and err <= (any nibble > 9), both visible after edge N.
  - data_valid=0: shadow holds. There is no back-pressure; every strobe is accepted.
  - Back-to-back strobes: the last one wins.
- Prescaler: counts 0..DIV-1 and wraps. On wrap, the slot index advances 0→1→2→3→0.
- Output registers: an and seg are registered. They reflect prescaler, index and shadow state one cycle late (latency 1).
- Dead interval: while prescaler < DEAD_CYCLES, an = 4'b1111 and seg = 7'b1111111.
- Active interval: one anode low, an[idx]=0. seg by slot:
  - idx 0: units, always shown.
  - idx 1: tens; blank if LZ_BLANK, tens == 0 and hundreds == 0.
  - idx 2: hundreds; blank if LZ_BLANK and hundreds == 0.
  - idx 3: anode stays high (digit unused), seg blank.
- Decode, active-low:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001.
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
  - Any nibble A–F shows dash 0111111 and is never blanked.
- Blanking rule with errors: an invalid upper nibble counts as non-zero for blanking.
- Load coinciding with a slot boundary: the new shadow drives the first active cycle of the new slot (normal latency 1); no special case.
- Reset mid-scan: returns to the reset state on the next edge. The first active cycle after reset is at cycle DEAD_CYCLES+1 in slot 0.
- data12 is ignored when data_valid=0.

Decomposition:
- Package bcd_disp_pkg holds:
  - the segment constants SEG_BLANK, SEG_DASH and the digit table;
  - DIV derivation and parameter-legality checks (elaboration error if DIV < 4 or DEAD_CYCLES >= DIV).
- Sub-module bcd_to_seg7: combinational nibble → seg with a blank input. It is instantiated once and fed by the slot-index mux.
- The top contains the shadow register, prescaler, index counter and output registers.

Test Plan (CLK_HZ=1000, SLOT_HZ=100 → DIV=10, DEAD_CYCLES=2, LZ_BLANK=1):
- Reset held 3 cycles → an=1111, seg=1111111, dp=1, err=0. Release → an[0] first goes low at cycle 3 after release, with seg=1000000 ("0").
- Strobe data12=12'h123 → per slot after the dead interval:
  - an=1110 with seg=0110000;
  - an=1101 with seg=0100100;
  - an=1011 with seg=1111001;
  - slot 3 all off.
  - Anodes are off for exactly 2 cycles at each slot start.
- Strobe 12'h007 → slot 0 shows 1111000; slots 1 and 2 have the anode low with seg=1111111. Strobe 12'h050 → slot 1 shows 0010010, slot 2 blank.
- Strobe 12'h3A1 → err=1 the cycle after the strobe; slot 1 shows 0111111. Then strobe 12'h001 → err=0 the next cycle.
- Strobes on two consecutive cycles, 12'h111 then 12'h222, → only "222" is ever displayed. Strobe on the slot-wrap edge → the new digit appears in the first active cycle of the next slot.
- Reset asserted mid-slot 2 → the next cycle returns to the reset state: an=1111, shadow 0, err 0, prescaler and index 0.
